modulo_controller: RTL and testbench
====================================

Name: modulo_controller

Overview:
- Control FSM directly upstream of the modulo datapath. It computes Zahl1 mod Zahl2 by repeated compare/subtract.
- Accepts a start request with two operands, then sequences the datapath's write-enable, register-transfer, ALU-mode and termination-check strobes.
- Reports done or error to the requester, with an iteration count.

Parameters:
- ALU_LAT, 2, cycles from ALU operand presentation to valid registered result on the datapath write-back bus.
- MAX_ITER, 16'hFFFF, maximum subtract iterations before aborting with error.
- MODE_CMP, 3'd2, alu_mode_o code for "result[0] = (a < b)".
- MODE_SUB, 3'd1, alu_mode_o code for "result = a - b".

Ports:
- clk  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only in IDLE.
- Zahl1_i  in  16  dividend; must be held stable from the accept cycle through LOAD.
- Zahl2_i  in  16  divisor; same stability rule.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse: result valid on the datapath ergebnis output.
- err_o  out  1  one-cycle pulse: operation aborted.
- err_code_o  out  2  01 = divisor zero, 10 = operand bit15 set, 11 = timeout; held until next accept.
- dp_start_o  out  1  one-cycle pulse to datapath start_i in the accept cycle.
- alu_mode_o  out  3  datapath ALU mode.
- wren_update_Zahlen_o  out  1  datapath operand-load strobe.
- wren_Zahl1_to_erg_o  out  1  ergebnis <= Zahl1.
- wren_term_erg_o  out  1  termination flag <= wbb[0].
- wren_res_to_erg_o  out  1  ergebnis <= wbb.
- erg_to_alu_a_o  out  1  ALU a <= ergebnis.
- Zahl2_to_alu_b_o  out  1  ALU b <= Zahl2.
- check_for_termination_o  out  1  qualifies datapath valid.
- valid_i  in  1  datapath valid_o (= check & termination flag).
- iter_cnt_o  out  16  subtraction count (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state, including mid-operation): FSM to IDLE; all outputs 0; internal counters 0; err_code_o = 00. No partial strobe may survive reset.
- All strobes are registered (Moore) outputs. At most one wren_* is high per cycle.
- Operand and mode outputs are held constant for the whole wait/write-back window of a phase.
- IDLE:
  - start_i=1 → accept: dp_start_o=1.
  - If Zahl2_i==0 → ERR with code 01.
  - Else if Zahl1_i[15] or Zahl2_i[15] → ERR with code 10 (the ALU compare is signed).
  - Else → LOAD.
- LOAD: wren_update_Zahlen_o=1 for 1 cycle (the datapath's operand capture is registered one cycle behind its inputs) → INIT.
- INIT: wren_Zahl1_to_erg_o=1 for 1 cycle → CMP.
- CMP:
  - erg_to_alu_a_o=1, Zahl2_to_alu_b_o=1, alu_mode_o=MODE_CMP for ALU_LAT cycles (wait counter).
  - Then 1 further cycle with the same drive plus wren_term_erg_o=1 → CHECK.
- CHECK: check_for_termination_o=1 for 1 cycle.
  - valid_i=1 → DONE.
  - Else if iter count == MAX_ITER → ERR with code 11.
  - Else → SUB.
- SUB:
  - Same operand drive with alu_mode_o=MODE_SUB for ALU_LAT cycles.
  - Then 1 cycle with wren_res_to_erg_o=1; iteration count +1 → CMP.
- DONE: done_o=1 for 1 cycle → IDLE.
- ERR: err_o=1 for 1 cycle → IDLE.
- Latency for S subtractions with ALU_LAT=2:
  - done_o in cycle 3 + (S+1)·4 + S·3 after the accept cycle (cycle 0).
  - Each compare costs ALU_LAT+2 cycles; each subtract costs ALU_LAT+1 cycles.
- start_i while busy_o=1: ignored, with no effect on the operation in flight.
- start_i in the same cycle as DONE/ERR: ignored. The next accept is possible in the following IDLE cycle.
- Iteration counter: 16-bit, saturates at MAX_ITER and never wraps; cleared on accept.

Optional Feature:
- Macro: MODULO_ITER_CNT_EN.
- Defined: iter_cnt_o drives the live iteration count and holds the final value after DONE/ERR until the next accept.
- Undefined: iter_cnt_o tied to 16'd0. The internal counter is still kept for the MAX_ITER timeout.

Test Plan:
- Zahl1=10, Zahl2=3, start pulse:
  - wren_res_to_erg_o asserted 3 times.
  - done_o at cycle 28; datapath ergebnis=1.
  - iter_cnt_o=3 with macro defined, 0 without.
- Zahl1=2, Zahl2=5: no SUB phase; done_o at cycle 7; ergebnis=2.
- Zahl2=0 (any Zahl1): err_o at cycle 1 with err_code_o=01; no wren_* ever asserted.
- MAX_ITER=4, Zahl1=100, Zahl2=1: err_o after 4th SUB and 5th CHECK with err_code_o=11; done_o never asserted.
- Second start_i pulse during SUB of a 9 mod 4 run: ignored; done_o once, ergebnis=1. A new start one cycle after done_o is accepted.
- rst_i asserted asynchronously mid-CMP: all outputs 0 immediately (before next clk edge); FSM in IDLE; a subsequent 7 mod 7 run gives ergebnis=0.

Source files
------------

// File: rtl/modulo_controller.sv
// modulo_controller: control FSM for a repeated compare/subtract modulo datapath.
// Computes Zahl1 mod Zahl2 by sequencing datapath strobes. All outputs are registered.
//
// Optional feature macro: MODULO_ITER_CNT_EN
//   defined   -> iter_cnt_o shows the live subtraction count, held after DONE/ERR
//   undefined -> iter_cnt_o is tied to zero (the count is still kept for the timeout)
//
// Ports:
//   clk, rst_i               clock (rising edge), asynchronous active-high reset
//   start_i, Zahl1_i/Zahl2_i request and operands (operands stable through LOAD)
//   busy_o, done_o, err_o    status; err_code_o: 01 div-by-zero, 10 bit15 set, 11 timeout
//   dp_start_o               pulse to the datapath on acceptance
//   alu_mode_o, wren_*_o, erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o
//                            datapath control strobes
//   valid_i                  datapath valid (check & termination flag)
//   iter_cnt_o               subtraction count
`timescale 1ns / 1ps

module modulo_controller #(
  parameter int unsigned ALU_LAT  = 2,
  parameter logic [15:0] MAX_ITER = 16'hFFFF,
  parameter logic [2:0]  MODE_CMP = 3'd2,
  parameter logic [2:0]  MODE_SUB = 3'd1
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] Zahl1_i,
  input  logic [15:0] Zahl2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        dp_start_o,
  output logic [2:0]  alu_mode_o,
  output logic        wren_update_Zahlen_o,
  output logic        wren_Zahl1_to_erg_o,
  output logic        wren_term_erg_o,
  output logic        wren_res_to_erg_o,
  output logic        erg_to_alu_a_o,
  output logic        Zahl2_to_alu_b_o,
  output logic        check_for_termination_o,
  input  logic        valid_i,
  output logic [15:0] iter_cnt_o
);

  localparam int unsigned WaitW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  // Last cycle of a phase (the write-back cycle) and the cycle before it.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ALU_LAT);
  localparam logic [WaitW-1:0] WaitPre  = WaitW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StInit, StCmp, StCheck, StSub, StDone, StErr
  } state_e;

  state_e           r_state;
  logic [WaitW-1:0] r_wait;
  logic [15:0]      r_iter;
  logic             r_busy, r_done, r_err, r_dp_start;
  logic [1:0]       r_err_code;
  logic [2:0]       r_alu_mode;
  logic             r_wren_upd, r_wren_z1, r_wren_term, r_wren_res;
  logic             r_erg_a, r_z2_b, r_check;

  // Only the sign bit of the dividend is inspected here; the datapath consumes the rest.
  logic w_unused_zahl1;
  assign w_unused_zahl1 = ^Zahl1_i[14:0];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_wait      <= '0;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_dp_start  <= 1'b0;
      r_err_code  <= 2'b00;
      r_alu_mode  <= 3'd0;
      r_wren_upd  <= 1'b0;
      r_wren_z1   <= 1'b0;
      r_wren_term <= 1'b0;
      r_wren_res  <= 1'b0;
      r_erg_a     <= 1'b0;
      r_z2_b      <= 1'b0;
      r_check     <= 1'b0;
    end else begin
      // Single-cycle pulses default low; operand/mode drive holds unless changed.
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_dp_start  <= 1'b0;
      r_wren_upd  <= 1'b0;
      r_wren_z1   <= 1'b0;
      r_wren_term <= 1'b0;
      r_wren_res  <= 1'b0;
      r_check     <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_dp_start <= 1'b1;
            r_busy     <= 1'b1;
            r_iter     <= '0;
            r_err_code <= 2'b00;
            if (Zahl2_i == 16'd0) begin
              r_state    <= StErr;
              r_err      <= 1'b1;
              r_err_code <= 2'b01;
            end else if (Zahl1_i[15] || Zahl2_i[15]) begin
              // Signed ALU compare cannot handle operands with bit15 set.
              r_state    <= StErr;
              r_err      <= 1'b1;
              r_err_code <= 2'b10;
            end else begin
              r_state    <= StLoad;
              r_wren_upd <= 1'b1;
            end
          end
        end

        StLoad: begin
          r_state   <= StInit;
          r_wren_z1 <= 1'b1;
        end

        StInit: begin
          r_state    <= StCmp;
          r_wait     <= '0;
          r_erg_a    <= 1'b1;
          r_z2_b     <= 1'b1;
          r_alu_mode <= MODE_CMP;
        end

        StCmp: begin
          if (r_wait == WaitLast) begin
            r_state    <= StCheck;
            r_check    <= 1'b1;
            r_erg_a    <= 1'b0;
            r_z2_b     <= 1'b0;
            r_alu_mode <= 3'd0;
          end else begin
            r_wait <= r_wait + 1'b1;
            if (r_wait == WaitPre) r_wren_term <= 1'b1;
          end
        end

        StCheck: begin
          if (valid_i) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else if (r_iter == MAX_ITER) begin
            r_state    <= StErr;
            r_err      <= 1'b1;
            r_err_code <= 2'b11;
          end else begin
            r_state    <= StSub;
            r_wait     <= '0;
            r_erg_a    <= 1'b1;
            r_z2_b     <= 1'b1;
            r_alu_mode <= MODE_SUB;
          end
        end

        StSub: begin
          if (r_wait == WaitLast) begin
            r_state    <= StCmp;
            r_wait     <= '0;
            r_alu_mode <= MODE_CMP;
            if (r_iter != MAX_ITER) r_iter <= r_iter + 16'd1;
          end else begin
            r_wait <= r_wait + 1'b1;
            if (r_wait == WaitPre) r_wren_res <= 1'b1;
          end
        end

        StDone, StErr: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o                  = r_busy;
  assign done_o                  = r_done;
  assign err_o                   = r_err;
  assign err_code_o              = r_err_code;
  assign dp_start_o              = r_dp_start;
  assign alu_mode_o              = r_alu_mode;
  assign wren_update_Zahlen_o    = r_wren_upd;
  assign wren_Zahl1_to_erg_o     = r_wren_z1;
  assign wren_term_erg_o         = r_wren_term;
  assign wren_res_to_erg_o       = r_wren_res;
  assign erg_to_alu_a_o          = r_erg_a;
  assign Zahl2_to_alu_b_o        = r_z2_b;
  assign check_for_termination_o = r_check;

`ifdef MODULO_ITER_CNT_EN
  assign iter_cnt_o = r_iter;
`else
  assign iter_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_modulo_controller.sv
// Bench for modulo_controller: a small datapath model closes the valid_i loop, and a
// timeline reference model predicts every output on every cycle.
`timescale 1ns / 1ps

module tb_modulo_controller;

  localparam int unsigned AluLat  = 2;
  localparam logic [15:0] MaxIter = 16'd4;
  localparam logic [2:0]  ModeCmp = 3'd2;
  localparam logic [2:0]  ModeSub = 3'd1;
  localparam int          CmpCost = AluLat + 2;  // compare phase incl. CHECK
  localparam int          SubCost = AluLat + 1;
  localparam int          Period  = CmpCost + SubCost;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] zahl1 = '0, zahl2 = '0;
  logic        busy_o, done_o, err_o, dp_start_o;
  logic [1:0]  err_code_o;
  logic [2:0]  alu_mode_o;
  logic        wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o;
  logic        erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o, valid_i;
  logic [15:0] iter_cnt_o;

  always #5 clk = ~clk;

  modulo_controller #(
    .ALU_LAT (AluLat),
    .MAX_ITER(MaxIter),
    .MODE_CMP(ModeCmp),
    .MODE_SUB(ModeSub)
  ) u_dut (
    .clk                    (clk),
    .rst_i                  (rst_i),
    .start_i                (start_i),
    .Zahl1_i                (zahl1),
    .Zahl2_i                (zahl2),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .err_o                  (err_o),
    .err_code_o             (err_code_o),
    .dp_start_o             (dp_start_o),
    .alu_mode_o             (alu_mode_o),
    .wren_update_Zahlen_o   (wren_update_Zahlen_o),
    .wren_Zahl1_to_erg_o    (wren_Zahl1_to_erg_o),
    .wren_term_erg_o        (wren_term_erg_o),
    .wren_res_to_erg_o      (wren_res_to_erg_o),
    .erg_to_alu_a_o         (erg_to_alu_a_o),
    .Zahl2_to_alu_b_o       (Zahl2_to_alu_b_o),
    .check_for_termination_o(check_for_termination_o),
    .valid_i                (valid_i),
    .iter_cnt_o             (iter_cnt_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [15:0] dp_z1, dp_z2, dp_erg;
  logic        dp_term;
  logic [15:0] pipe [AluLat];

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [2:0] mode);
    if (mode == ModeCmp) return {15'd0, ($signed(a) < $signed(b))};
    if (mode == ModeSub) return a - b;
    return 16'd0;
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      dp_z1 <= '0; dp_z2 <= '0; dp_erg <= '0; dp_term <= 1'b0;
      for (int i = 0; i < AluLat; i++) pipe[i] <= '0;
    end else begin
      if (wren_update_Zahlen_o) begin dp_z1 <= zahl1; dp_z2 <= zahl2; end
      if (wren_Zahl1_to_erg_o) dp_erg <= dp_z1;
      if (wren_res_to_erg_o) dp_erg <= pipe[AluLat-1];
      if (wren_term_erg_o) dp_term <= pipe[AluLat-1][0];
      pipe[0] <= alu(erg_to_alu_a_o ? dp_erg : 16'd0, Zahl2_to_alu_b_o ? dp_z2 : 16'd0,
                     alu_mode_o);
      for (int i = 1; i < AluLat; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign valid_i = check_for_termination_o & dp_term;

  // ---------------- reference model: offset of the current cycle within an operation ----
  int          m_off = 0;    // 0 = idle, 1 = first cycle after accept
  int          m_end = 0;    // offset of the DONE/ERR cycle
  int          m_nsub = 0;
  bit          m_err = 1'b0;
  logic [1:0]  m_code = '0, m_code_hold = '0;
  logic [15:0] m_cnt_hold = '0, m_res = '0;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_off = 0; m_code_hold = '0; m_cnt_hold = '0;
    end else if (m_off == 0) begin
      if (start_i) begin
        m_off = 1;
        if (zahl2 == 16'd0 || zahl1[15] || zahl2[15]) begin
          m_err = 1'b1; m_end = 1; m_nsub = 0;
          m_code = (zahl2 == 16'd0) ? 2'b01 : 2'b10;
        end else if (int'(zahl1) / int'(zahl2) <= int'(MaxIter)) begin
          m_err = 1'b0; m_code = 2'b00;
          m_nsub = int'(zahl1) / int'(zahl2);
          m_res = zahl1 % zahl2;
          m_end = 3 + (m_nsub + 1) * CmpCost + m_nsub * SubCost;
        end else begin
          m_err = 1'b1; m_code = 2'b11; m_nsub = int'(MaxIter);
          m_end = 3 + (m_nsub + 1) * CmpCost + m_nsub * SubCost;
        end
      end
    end else if (m_off == m_end) begin
      m_off = 0;
      m_code_hold = m_code;
`ifdef MODULO_ITER_CNT_EN
      m_cnt_hold = 16'(m_nsub);
`else
      m_cnt_hold = 16'd0;
`endif
    end else begin
      m_off++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [13:0] act_v, exp_v;
    logic        e_busy, e_done, e_err, e_dps, e_upd, e_z1, e_term, e_res, e_a, e_b, e_chk;
    logic [2:0]  e_mode;
    logic [1:0]  e_code;
    logic [15:0] e_cnt;
    int          r;
    {e_busy, e_done, e_err, e_dps, e_upd, e_z1, e_term, e_res, e_a, e_b, e_chk} = '0;
    e_mode = 3'd0;
    e_code = m_code_hold;
    e_cnt  = m_cnt_hold;
    if (m_off != 0) begin
      e_busy = 1'b1;
      e_code = 2'b00;
      e_dps  = (m_off == 1);
      e_cnt  = 16'd0;
`ifdef MODULO_ITER_CNT_EN
      // k-th subtraction writes back at offset 2 + Period*(k+1)
      if (m_off > 2 + Period) begin
        r = (m_off - 3 - Period) / Period + 1;
        e_cnt = 16'((r < m_nsub) ? r : m_nsub);
      end
`endif
      if (m_off == m_end) begin
        if (m_err) begin e_err = 1'b1; e_code = m_code; end
        else e_done = 1'b1;
      end else if (m_off == 1) begin
        e_upd = 1'b1;
      end else if (m_off == 2) begin
        e_z1 = 1'b1;
      end else begin
        r = (m_off - 3) % Period;
        if (r <= AluLat) begin
          e_a = 1'b1; e_b = 1'b1; e_mode = ModeCmp; e_term = (r == AluLat);
        end else if (r == AluLat + 1) begin
          e_chk = 1'b1;
        end else begin
          e_a = 1'b1; e_b = 1'b1; e_mode = ModeSub; e_res = (r == Period - 1);
        end
      end
    end
    exp_v = {e_busy, e_done, e_err, e_dps, e_upd, e_z1, e_term, e_res, e_a, e_b, e_chk, e_mode};
    act_v = {busy_o, done_o, err_o, dp_start_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o,
             wren_term_erg_o, wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o,
             check_for_termination_o, alu_mode_o};
    chk("strobes", 32'(act_v), 32'(exp_v));
    chk("err_code", 32'(err_code_o), 32'(e_code));
    chk("iter_cnt", 32'(iter_cnt_o), 32'(e_cnt));
    if (e_done) chk("ergebnis", 32'(dp_erg), 32'(m_res));
  end

  // ---------------- stimulus ----------------
  int          end_off, n_res, n_done, n_wren;
  bit          got_err;
  logic [15:0] erg_end;

  // Called right after a negedge; returns right after the negedge following DONE/ERR.
  task automatic run_op(input logic [15:0] z1, input logic [15:0] z2, input int extra_off,
                        input bit scramble);
    int  off;
    bit  seen;
    start_i = 1'b1; zahl1 = z1; zahl2 = z2;
    @(negedge clk);
    off = 1; seen = 1'b0; end_off = -1; n_res = 0; n_done = 0; n_wren = 0; got_err = 1'b0;
    while (!seen && off < 100) begin
      n_res += int'(wren_res_to_erg_o);
      n_done += int'(done_o);
      n_wren += int'(wren_update_Zahlen_o) + int'(wren_Zahl1_to_erg_o) +
                int'(wren_term_erg_o) + int'(wren_res_to_erg_o);
      if (done_o || err_o) begin
        seen = 1'b1; end_off = off; got_err = err_o; erg_end = dp_erg;
      end
      start_i = (off == extra_off);
      if (scramble && off >= 2) begin zahl1 = 16'($urandom); zahl2 = 16'($urandom); end
      @(negedge clk);
      off++;
    end
    start_i = 1'b0;
    if (!seen) chk("op_terminates", 32'(0), 32'(1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("reset_busy", 32'(busy_o), 32'(0));
    chk("reset_code", 32'(err_code_o), 32'(0));

    // 10 mod 3: three subtractions, done at cycle 28
    run_op(16'd10, 16'd3, 0, 1'b0);
    chk("10mod3_done_cycle", 32'(end_off), 32'(28));
    chk("10mod3_is_done", 32'(got_err), 32'(0));
    chk("10mod3_sub_count", 32'(n_res), 32'(3));
    chk("10mod3_result", 32'(erg_end), 32'(1));
`ifdef MODULO_ITER_CNT_EN
    chk("10mod3_iter_cnt", 32'(iter_cnt_o), 32'(3));
`else
    chk("10mod3_iter_cnt", 32'(iter_cnt_o), 32'(0));
`endif

    // 2 mod 5: no subtract phase
    run_op(16'd2, 16'd5, 0, 1'b0);
    chk("2mod5_done_cycle", 32'(end_off), 32'(7));
    chk("2mod5_result", 32'(erg_end), 32'(2));
    chk("2mod5_sub_count", 32'(n_res), 32'(0));

    // Divisor zero
    run_op(16'h1234, 16'd0, 0, 1'b0);
    chk("div0_err_cycle", 32'(end_off), 32'(1));
    chk("div0_is_err", 32'(got_err), 32'(1));
    chk("div0_code", 32'(err_code_o), 32'(1));
    chk("div0_no_wren", 32'(n_wren), 32'(0));

    // Timeout: 100 mod 1 with MaxIter = 4
    run_op(16'd100, 16'd1, 0, 1'b0);
    chk("timeout_err_cycle", 32'(end_off), 32'(35));
    chk("timeout_is_err", 32'(got_err), 32'(1));
    chk("timeout_code", 32'(err_code_o), 32'(3));
    chk("timeout_no_done", 32'(n_done), 32'(0));
    chk("timeout_sub_count", 32'(n_res), 32'(4));

    // 9 mod 4 with a second start during the first SUB, then back-to-back start
    run_op(16'd9, 16'd4, 9, 1'b0);
    chk("9mod4_done_cycle", 32'(end_off), 32'(21));
    chk("9mod4_done_once", 32'(n_done), 32'(1));
    chk("9mod4_result", 32'(erg_end), 32'(1));
    run_op(16'd20, 16'd6, 0, 1'b0);
    chk("b2b_done_cycle", 32'(end_off), 32'(28));
    chk("b2b_result", 32'(erg_end), 32'(2));

    // Asynchronous reset in the middle of a compare phase
    start_i = 1'b1; zahl1 = 16'd50; zahl2 = 16'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("midcmp_drive", 32'({erg_to_alu_a_o, alu_mode_o}), 32'({1'b1, ModeCmp}));
    #2 rst_i = 1'b1;
    #1 chk("async_reset_outputs",
           32'({busy_o, done_o, err_o, dp_start_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o,
                wren_term_erg_o, wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o,
                check_for_termination_o, alu_mode_o, err_code_o}), 32'(0));
    chk("async_reset_iter", 32'(iter_cnt_o), 32'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    run_op(16'd7, 16'd7, 0, 1'b0);
    chk("7mod7_done_cycle", 32'(end_off), 32'(14));
    chk("7mod7_result", 32'(erg_end), 32'(0));

    // Randomized operations, checked cycle by cycle by the compare process
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a, b;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = 16'd0;
      else if (sel == 1) b = 16'h8000 | 16'($urandom_range(0, 100));
      else b = 16'($urandom_range(1, 20));
      a = ($urandom_range(0, 9) == 0) ? (16'h8000 | 16'($urandom)) : 16'($urandom_range(0, 120));
      run_op(a, b, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
